stat_display: RTL and testbench
===============================

Name: stat_display

Overview:
- Consumes the counter outputs of the statistics stage (cycle count, unconditional-branch count, conditional-branch count, taken-conditional count, syscall-34 display value) and the halt flag.
- Selects one value with a front-panel selector and snapshots it.
- Drives an 8-digit, time-multiplexed, active-low seven-segment display in hex.
- Sits at the top level between the statistics stage and the board display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan advances (≥2).
- BLANK_LZ, 1, 1 = blank leading-zero digits above the most significant non-zero nibble; digit 0 is never blanked.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- total_cycles  input  32  selector code 0
- uncondi_num  input  32  selector code 1
- condi_num  input  32  selector code 2
- condi_suc_num  input  32  selector code 3
- SyscallOut  input  32  selector code 4
- halt  input  1  processor halt request (syscall 10)
- sel  input  3  value select; codes 5–7 select constant 0
- hold  input  1  1 = freeze the snapshot
- shown_value  output  32  registered snapshot being displayed
- halted  output  1  sticky halt indicator
- an  output  8  digit enables, active low; an[i] = digit i, digit 0 = least significant nibble
- seg  output  8  segments, active low; seg[6:0] = g..a, seg[7] = dp

Behaviour:
- Reset values: shown_value=0, halted=0, an=8'hFF, seg=8'hFF, scan divider=0, digit index=0. Reset mid-scan aborts the scan; the next edge after reset release drives digit 0.
- Snapshot:
  - Each edge with hold=0: shown_value <= value chosen by sel. One-cycle latency.
  - hold=1: shown_value keeps its value.
  - Changing sel does not disturb the scan divider or the digit index.
- Halt latch:
  - halted <= 1 on any edge with halt=1.
  - Cleared only by rst.
  - halt does not freeze the snapshot; hold does that.
- Scan divider:
  - Counts 0..SCAN_DIV-1; on the terminal count it wraps to 0 and the digit index increments mod 8 (7→0).
  - Each digit is therefore active for exactly SCAN_DIV cycles.
- Output registers (updated every edge from the current digit index idx and shown_value):
  - an <= ~(8'b1 << idx).
  - nibble = shown_value[4*idx+3 : 4*idx].
  - seg[6:0] <= hex code of nibble: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values listed as 8-bit with dp off).
  - seg[7] <= 0 (dp lit) only when idx==0 and halted==1; otherwise 1.
  - Blanking, when BLANK_LZ=1 and idx>0 and every nibble from idx up to 7 is zero: an <= 8'hFF and seg <= 8'hFF for that slot. The slot time is still consumed, so brightness is uniform.
  - an and seg always change on the same edge. They lag shown_value and idx by one cycle.
- Simultaneous events: halt with hold on the same edge → both take effect. sel change on a scan wrap edge → new digit index shows the old snapshot for one cycle, then the new snapshot.

Test Plan:
- Reset check, SCAN_DIV=4: assert rst for 3 cycles → an=FF, seg=FF, shown_value=0, halted=0. After release, next edge an=FE, seg=C0.
- Scan walk, SCAN_DIV=4, BLANK_LZ=0, sel=0, total_cycles=32'h89ABCDEF:
  - shown_value=89ABCDEF one cycle later.
  - Digit 0 shows seg=8E (F) for 4 cycles with an=FE; then an=FD shows 86 (E); and so on up to an=7F showing 80 (8); then wraps to an=FE.
- Selection: condi_suc_num=5, SyscallOut=32'h1234, sel 3→4→6 → shown_value 5 → 1234 → 0, each one cycle after the sel change.
- Hold: sel=0, total_cycles incrementing every cycle, hold=1 at value 100 → shown_value stays 100 while held. Release hold → shown_value tracks again on the next edge.
- Halt: pulse halt for 1 cycle with shown_value=7, idx=0 → halted=1 permanently; digit 0 seg=78 (7 with dp). Only rst clears halted.
- Blanking, BLANK_LZ=1, shown_value=32'h00000A30 → digits 0..2 show C0, B0, 88 with an active. Digits 3..7 produce an=FF, seg=FF in their slots. Value 0 → only digit 0 lit, seg=C0.

Source files
------------

// File: rtl/stat_display.sv
// Statistics value selector with snapshot, sticky halt flag and an
// 8-digit multiplexed active-low hex seven-segment driver.
module stat_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_num,
  input  logic [31:0] condi_num,
  input  logic [31:0] condi_suc_num,
  input  logic [31:0] SyscallOut,
  input  logic        halt,
  input  logic [2:0]  sel,
  input  logic        hold,
  output logic [31:0] shown_value,
  output logic        halted,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [31:0]   shown_value_q, shown_value_d;
  logic          halted_q, halted_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic [31:0] sel_value;
  logic [31:0] upper;
  logic [3:0]  nibble;
  logic        blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  always_comb begin
    case (sel)
      3'd0:    sel_value = total_cycles;
      3'd1:    sel_value = uncondi_num;
      3'd2:    sel_value = condi_num;
      3'd3:    sel_value = condi_suc_num;
      3'd4:    sel_value = SyscallOut;
      default: sel_value = 32'd0;
    endcase
  end

  always_comb begin
    shown_value_d = hold ? shown_value_q : sel_value;
    halted_d      = halted_q | halt;
    div_d         = div_q + 1'b1;
    idx_d         = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Leading-zero test: everything from the current digit upward is zero.
  always_comb begin
    upper  = shown_value_q >> {idx_q, 2'b00};
    nibble = shown_value_q[{idx_q, 2'b00} +: 4];
    blank  = BLANK_LZ && (idx_q != 3'd0) && (upper == 32'd0);
    an_d   = ~(8'h01 << idx_q);
    seg_d  = {~((idx_q == 3'd0) && halted_q), hex7(nibble)};
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shown_value_q <= 32'd0;
      halted_q      <= 1'b0;
      div_q         <= '0;
      idx_q         <= 3'd0;
      an_q          <= 8'hFF;
      seg_q         <= 8'hFF;
    end else begin
      shown_value_q <= shown_value_d;
      halted_q      <= halted_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign shown_value = shown_value_q;
  assign halted      = halted_q;
  assign an          = an_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_stat_display.sv
// Directed bench for stat_display: a selection/hold/halt vector
// table plus hand-written scan, blanking and halt sequences.
module tb_stat_display;

  logic        clk;
  logic        rst;
  logic [31:0] total_cycles;
  logic [31:0] uncondi_num;
  logic [31:0] condi_num;
  logic [31:0] condi_suc_num;
  logic [31:0] SyscallOut;
  logic        halt;
  logic [2:0]  sel;
  logic        hold;

  logic [31:0] sv0, sv1;
  logic        halted0, halted1;
  logic [7:0]  an0, an1, seg0, seg1;

  int n_pass;
  int n_total;

  stat_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .total_cycles(total_cycles),
    .uncondi_num(uncondi_num), .condi_num(condi_num),
    .condi_suc_num(condi_suc_num), .SyscallOut(SyscallOut),
    .halt(halt), .sel(sel), .hold(hold),
    .shown_value(sv0), .halted(halted0), .an(an0), .seg(seg0)
  );

  stat_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .total_cycles(total_cycles),
    .uncondi_num(uncondi_num), .condi_num(condi_num),
    .condi_suc_num(condi_suc_num), .SyscallOut(SyscallOut),
    .halt(halt), .sel(sel), .hold(hold),
    .shown_value(sv1), .halted(halted1), .an(an1), .seg(seg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  sel;
    logic        hold;
    logic        halt;
    logic [31:0] tc;
    logic [31:0] exp_sv;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[16];

  logic [7:0] hexc[16];
  logic [7:0] blk_an[8];
  logic [7:0] blk_seg[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] val;
    logic [7:0]  e_an;
    int          idx;
    n_pass  = 0;
    n_total = 0;

    hexc = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    blk_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    blk_seg = '{8'hC0, 8'hB0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    vecs[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 32'd0,   32'd0,      1'b0};
    vecs[1]  = '{1'b0, 3'd3, 1'b0, 1'b0, 32'd0,   32'd5,      1'b0};
    vecs[2]  = '{1'b0, 3'd4, 1'b0, 1'b0, 32'd0,   32'h1234,   1'b0};
    vecs[3]  = '{1'b0, 3'd6, 1'b0, 1'b0, 32'd0,   32'd0,      1'b0};
    vecs[4]  = '{1'b0, 3'd1, 1'b0, 1'b0, 32'd0,   32'd11,     1'b0};
    vecs[5]  = '{1'b0, 3'd2, 1'b0, 1'b0, 32'd0,   32'd22,     1'b0};
    vecs[6]  = '{1'b0, 3'd7, 1'b0, 1'b0, 32'd0,   32'd0,      1'b0};
    vecs[7]  = '{1'b0, 3'd5, 1'b0, 1'b0, 32'd0,   32'd0,      1'b0};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'd99,  32'd99,     1'b0};
    vecs[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'd100, 32'd100,    1'b0};
    vecs[10] = '{1'b0, 3'd0, 1'b1, 1'b0, 32'd101, 32'd100,    1'b0};
    vecs[11] = '{1'b0, 3'd0, 1'b1, 1'b0, 32'd102, 32'd100,    1'b0};
    vecs[12] = '{1'b0, 3'd0, 1'b1, 1'b1, 32'd103, 32'd100,    1'b1};
    vecs[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'd104, 32'd104,    1'b1};
    vecs[14] = '{1'b0, 3'd3, 1'b0, 1'b0, 32'd105, 32'd5,      1'b1};
    vecs[15] = '{1'b1, 3'd3, 1'b0, 1'b0, 32'd106, 32'd0,      1'b0};

    uncondi_num   = 32'd11;
    condi_num     = 32'd22;
    condi_suc_num = 32'd5;
    SyscallOut    = 32'h1234;
    total_cycles  = 32'd0;
    halt          = 1'b0;
    sel           = 3'd0;
    hold          = 1'b0;
    rst           = 1'b1;

    // Reset state, then first digit after release.
    do_reset(3);
    chk("rst_an", {24'd0, an0}, 32'hFF);
    chk("rst_seg", {24'd0, seg0}, 32'hFF);
    chk("rst_sv", sv0, 32'd0);
    chk("rst_halted", {31'd0, halted0}, 32'd0);
    step();
    chk("rel_an", {24'd0, an0}, 32'hFE);
    chk("rel_seg", {24'd0, seg0}, 32'hC0);

    // Full scan walk with wrap, no blanking.
    val = 32'h89ABCDEF;
    total_cycles = val;
    do_reset(1);
    step();
    chk("walk_sv", sv0, val);
    for (int c = 2; c <= 36; c++) begin
      step();
      idx  = ((c - 1) / 4) % 8;
      e_an = 8'h01 << idx;
      e_an = ~e_an;
      chk($sformatf("walk_an_c%0d", c), {24'd0, an0}, {24'd0, e_an});
      chk($sformatf("walk_seg_c%0d", c), {24'd0, seg0},
          {24'd0, hexc[val[4*idx +: 4]]});
    end

    // Leading-zero blanking on A30 and on zero.
    val = 32'h00000A30;
    total_cycles = val;
    do_reset(1);
    step();
    chk("blk_sv", sv1, val);
    for (int c = 2; c <= 33; c++) begin
      step();
      idx = ((c - 1) / 4) % 8;
      chk($sformatf("blk_an_c%0d", c), {24'd0, an1}, {24'd0, blk_an[idx]});
      chk($sformatf("blk_seg_c%0d", c), {24'd0, seg1}, {24'd0, blk_seg[idx]});
      chk($sformatf("noblk_seg_c%0d", c), {24'd0, seg0},
          {24'd0, hexc[val[4*idx +: 4]]});
    end
    total_cycles = 32'd0;
    do_reset(1);
    step();
    for (int c = 2; c <= 33; c++) begin
      step();
      idx = ((c - 1) / 4) % 8;
      chk($sformatf("zero_an_c%0d", c), {24'd0, an1},
          (idx == 0) ? 32'hFE : 32'hFF);
      chk($sformatf("zero_seg_c%0d", c), {24'd0, seg1},
          (idx == 0) ? 32'hC0 : 32'hFF);
    end

    // Halt pulse: sticky flag and decimal point on digit 0 only.
    total_cycles = 32'd7;
    do_reset(1);
    step();
    chk("halt_sv", sv0, 32'd7);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_set", {31'd0, halted0}, 32'd1);
    step();
    chk("halt_dp_c3", {24'd0, seg0}, 32'h78);
    step();
    chk("halt_dp_c4", {24'd0, seg0}, 32'h78);
    step();
    chk("halt_d1_an", {24'd0, an0}, 32'hFD);
    chk("halt_d1_seg", {24'd0, seg0}, 32'hC0);
    for (int c = 6; c <= 33; c++) step();
    chk("halt_wrap_seg", {24'd0, seg0}, 32'h78);
    chk("halt_sticky", {31'd0, halted0}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt_clr", {31'd0, halted0}, 32'd0);

    // Selection, hold and halt-with-hold vectors.
    for (int i = 0; i < 16; i++) begin
      rst          = vecs[i].rst;
      sel          = vecs[i].sel;
      hold         = vecs[i].hold;
      halt         = vecs[i].halt;
      total_cycles = vecs[i].tc;
      step();
      chk($sformatf("vec%0d_sv", i), sv0, vecs[i].exp_sv);
      chk($sformatf("vec%0d_halted", i), {31'd0, halted0},
          {31'd0, vecs[i].exp_halted});
    end
    rst  = 1'b0;
    halt = 1'b0;
    hold = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
